// File: rtl/riscv_muldiv_execute_pkg.sv
// Shared RV32M/RV64M definitions: default XLEN, funct3 opcodes and operand-signedness helpers.
package riscv_muldiv_execute_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // MULHSU: rs1 signed, rs2 unsigned. MUL is treated as signed x signed; its low half is sign-agnostic.
    function automatic logic op_rs1_signed(input logic [2:0] f3);
        return (f3 == OP_MUL) || (f3 == OP_MULH) || (f3 == OP_MULHSU) ||
               (f3 == OP_DIV) || (f3 == OP_REM);
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] f3);
        return (f3 == OP_MUL) || (f3 == OP_MULH) || (f3 == OP_DIV) || (f3 == OP_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_execute.sv
// Iterative M-extension multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency XLEN+1 cycles from accept to done; 1 cycle for divide-by-zero and signed overflow.
// Stall holds the decode/execute register from accept until the final CALC cycle; flush drops it at once.
module riscv_muldiv_execute
    import riscv_muldiv_execute_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESULT_INIT = '0
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_muldiv_valid,
    input  logic [2:0]      i_muldiv_funct3,
    input  logic [XLEN-1:0] i_muldiv_rs1,
    input  logic [XLEN-1:0] i_muldiv_rs2,
    input  logic            i_muldiv_flush,
    output logic            o_muldiv_stall,
    output logic            o_muldiv_done,
    output logic [XLEN-1:0] o_muldiv_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic [XLEN-1:0]     a_mag_q;
    logic [XLEN-1:0]     b_mag_q;
    logic [2*XLEN-1:0]   prod_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    // ---------------- operand capture ----------------
    logic                accept;
    logic                a_neg_in, b_neg_in;
    logic [XLEN-1:0]     a_mag_in, b_mag_in;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;

    assign accept   = (state_q == S_IDLE) && i_muldiv_valid && !i_muldiv_flush;
    assign a_neg_in = op_rs1_signed(i_muldiv_funct3) && i_muldiv_rs1[XLEN-1];
    assign b_neg_in = op_rs2_signed(i_muldiv_funct3) && i_muldiv_rs2[XLEN-1];
    assign a_mag_in = a_neg_in ? -i_muldiv_rs1 : i_muldiv_rs1;
    assign b_mag_in = b_neg_in ? -i_muldiv_rs2 : i_muldiv_rs2;

    assign div_zero = op_is_div(i_muldiv_funct3) && (i_muldiv_rs2 == '0);
    assign div_ovf  = ((i_muldiv_funct3 == OP_DIV) || (i_muldiv_funct3 == OP_REM)) &&
                      (i_muldiv_rs1 == MIN_NEG) && (i_muldiv_rs2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_is_rem(i_muldiv_funct3) ? i_muldiv_rs1 : '1;
        end else begin
            special_res = op_is_rem(i_muldiv_funct3) ? '0 : i_muldiv_rs1;
        end
    end

    // ---------------- one iteration step ----------------
    // Multiply: multiplier sits in the low half and shifts out LSB-first while partial sums enter the top.
    logic [XLEN:0]       mul_hi_sum;
    logic [2*XLEN-1:0]   mul_next;
    assign mul_hi_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    assign mul_next   = {mul_hi_sum, prod_q[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend bits out and quotient bits in.
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       rem_diff;
    logic                rem_ge;
    logic [2*XLEN-1:0]   div_next;
    assign rem_sh   = prod_q[2*XLEN-1:XLEN-1];
    assign rem_diff = rem_sh - {1'b0, b_mag_q};
    assign rem_ge   = !rem_diff[XLEN];
    assign div_next = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), prod_q[XLEN-2:0], rem_ge};

    logic [2*XLEN-1:0]   step_next;
    assign step_next = op_is_div(op_q) ? div_next : mul_next;

    // ---------------- sign correction and result select ----------------
    logic [2*XLEN-1:0]   mul_full;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     quo_res;
    logic [XLEN-1:0]     rem_res;
    logic [XLEN-1:0]     calc_res;

    assign mul_full = q_neg_q ? -step_next : step_next;
    assign mul_res  = (op_q == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    assign quo_res  = q_neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    assign rem_res  = r_neg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    assign calc_res = !op_is_div(op_q) ? mul_res : (op_is_rem(op_q) ? rem_res : quo_res);

    // ---------------- FSM next state / stall ----------------
    logic stall_d;

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_d = 1'b1;
                    state_d = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // valid still high here belongs to the instruction just finished
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (i_muldiv_flush) begin
            state_d = S_IDLE;
            stall_d = 1'b0;
        end
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= RESULT_INIT;
            op_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            prod_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            if (accept) begin
                op_q    <= i_muldiv_funct3;
                q_neg_q <= a_neg_in ^ b_neg_in;
                r_neg_q <= a_neg_in;
                a_mag_q <= a_mag_in;
                b_mag_q <= b_mag_in;
                prod_q  <= op_is_div(i_muldiv_funct3) ? {{XLEN{1'b0}}, a_mag_in}
                                                       : {{XLEN{1'b0}}, b_mag_in};
                cnt_q   <= CW'(XLEN - 1);
                if (special) begin
                    result_q <= special_res;
                end
            end else if ((state_q == S_CALC) && !i_muldiv_flush) begin
                prod_q <= step_next;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_q <= calc_res;
                end
            end
        end
    end

    assign o_muldiv_stall  = stall_d;
    assign o_muldiv_done   = done_q;
    assign o_muldiv_result = result_q;

endmodule
